// File: rtl/vending_ctrl_change.sv
// rtl/vending_ctrl_change.sv - coin-credit vending controller with serial change and refund
module vending_ctrl_change #(
    parameter int PRICE       = 20,
    parameter int CHANGE_UNIT = 5,
    parameter int COIN0_VAL   = 5,
    parameter int COIN1_VAL   = 10,
    parameter int COIN2_VAL   = 25,
    parameter int CREDIT_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          coin_in,
    input  logic                cancel,
    output logic                product,
    output logic                change_coin,
    output logic                refunding,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {COLLECT, VEND, CHANGE, REFUND} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W-1:0] COIN0_C = CREDIT_W'(COIN0_VAL);
    localparam logic [CREDIT_W-1:0] COIN1_C = CREDIT_W'(COIN1_VAL);
    localparam logic [CREDIT_W-1:0] COIN2_C = CREDIT_W'(COIN2_VAL);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  reject_q, reject_d;
    logic [CREDIT_W-1:0]   win_val;
    logic [2:0]            win_mask;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Lowest-numbered coin wins; the rest only contribute to coin_reject.
    always_comb begin
        win_val  = '0;
        win_mask = 3'b000;
        if (coin_in[0]) begin
            win_val  = COIN0_C;
            win_mask = 3'b001;
        end else if (coin_in[1]) begin
            win_val  = COIN1_C;
            win_mask = 3'b010;
        end else if (coin_in[2]) begin
            win_val  = COIN2_C;
            win_mask = 3'b100;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            COLLECT: begin
                if (cancel && (credit_q != '0)) begin
                    state_d  = REFUND;
                    reject_d = |coin_in;
                end else begin
                    reject_d = |(coin_in & ~win_mask);
                    if (|coin_in) begin
                        credit_d = credit_q + win_val;
                        if (credit_d >= PRICE_C) state_d = VEND;
                    end
                end
            end
            VEND: begin
                reject_d = |coin_in;
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_d != '0) ? CHANGE : COLLECT;
            end
            CHANGE, REFUND: begin
                reject_d = |coin_in;
                credit_d = credit_q - UNIT_C;
                if (credit_d == '0) state_d = COLLECT;
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
            end
        endcase
    end

    assign product     = (state_q == VEND);
    assign change_coin = (state_q == CHANGE) || (state_q == REFUND);
    assign refunding   = (state_q == REFUND);
    assign busy        = (state_q != COLLECT);
    assign coin_reject = reject_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_vending_ctrl_change.sv
// tb/tb_vending_ctrl_change.sv - scoreboard bench for vending_ctrl_change
module tb_vending_ctrl_change;

    typedef struct packed {
        logic       refunding;
        logic [7:0] credit;
    } chg_t;

    logic       clock;
    logic       reset_a, reset_b;
    logic [2:0] coin_a, coin_b;
    logic       cancel_a, cancel_b;
    logic       product_a, change_a, refunding_a, reject_a, busy_a;
    logic [7:0] credit_a;
    logic       product_b, change_b, refunding_b, reject_b, busy_b;
    logic [6:0] credit_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_prod[$];
    logic [7:0] q_rej[$];
    chg_t       q_chg[$];

    vending_ctrl_change dut_a (
        .clock(clock), .reset(reset_a), .coin_in(coin_a), .cancel(cancel_a),
        .product(product_a), .change_coin(change_a), .refunding(refunding_a),
        .coin_reject(reject_a), .busy(busy_a), .credit(credit_a)
    );

    vending_ctrl_change #(.PRICE(35), .COIN2_VAL(50), .CREDIT_W(7)) dut_b (
        .clock(clock), .reset(reset_b), .coin_in(coin_b), .cancel(cancel_b),
        .product(product_b), .change_coin(change_b), .refunding(refunding_b),
        .coin_reject(reject_b), .busy(busy_b), .credit(credit_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every output pulse of dut_a must match the next expected entry of its queue.
    always @(negedge clock) begin
        if (!reset_a) begin
            if (product_a) begin
                checks++;
                if (q_prod.size() == 0) begin
                    errors++;
                    $display("FAIL product_unexpected: credit=%0d, no product expected", credit_a);
                end else begin
                    logic [7:0] exp_c;
                    exp_c = q_prod.pop_front();
                    if (credit_a !== exp_c) begin
                        errors++;
                        $display("FAIL product_credit: got %0d expected %0d", credit_a, exp_c);
                    end
                end
            end
            if (change_a) begin
                checks++;
                if (q_chg.size() == 0) begin
                    errors++;
                    $display("FAIL change_unexpected: credit=%0d refunding=%0b", credit_a, refunding_a);
                end else begin
                    chg_t exp_e;
                    exp_e = q_chg.pop_front();
                    if ({refunding_a, credit_a} !== exp_e) begin
                        errors++;
                        $display("FAIL change_pulse: got refunding=%0b credit=%0d expected refunding=%0b credit=%0d",
                                 refunding_a, credit_a, exp_e.refunding, exp_e.credit);
                    end
                end
            end
            if (reject_a) begin
                checks++;
                if (q_rej.size() == 0) begin
                    errors++;
                    $display("FAIL reject_unexpected: credit=%0d", credit_a);
                end else begin
                    logic [7:0] exp_r;
                    exp_r = q_rej.pop_front();
                    if (credit_a !== exp_r) begin
                        errors++;
                        $display("FAIL reject_credit: got %0d expected %0d", credit_a, exp_r);
                    end
                end
            end
        end
    end

    task automatic drive_a(input logic [2:0] c, input logic x);
        coin_a   = c;
        cancel_a = x;
        @(posedge clock);
        #1;
        coin_a   = 3'b000;
        cancel_a = 1'b0;
    endtask

    task automatic wait_idle_drained(input string name);
        for (int i = 0; i < 40 && busy_a; i++) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (busy_a) begin
            errors++;
            $display("FAIL %s_timeout: busy=%0b expected 0 within 40 cycles", name, busy_a);
        end
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (q_prod.size() + q_chg.size() + q_rej.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: pending prod=%0d chg=%0d rej=%0d expected 0",
                     name, q_prod.size(), q_chg.size(), q_rej.size());
        end
        q_prod.delete();
        q_chg.delete();
        q_rej.delete();
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        coin_a = 3'b000; coin_b = 3'b000;
        cancel_a = 1'b0; cancel_b = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({product_a, change_a, refunding_a, reject_a, busy_a, credit_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got p=%0b c=%0b r=%0b j=%0b b=%0b credit=%0d expected all 0",
                     product_a, change_a, refunding_a, reject_a, busy_a, credit_a);
        end
        reset_a = 1'b0; reset_b = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_exact_price();
        q_prod.push_back(8'd20);
        drive_a(3'b001, 1'b0);
        checks++;
        if (credit_a !== 8'd5) begin errors++; $display("FAIL exact_credit1: got %0d expected 5", credit_a); end
        drive_a(3'b001, 1'b0);
        checks++;
        if (credit_a !== 8'd10) begin errors++; $display("FAIL exact_credit2: got %0d expected 10", credit_a); end
        drive_a(3'b010, 1'b0);
        checks++;
        if (credit_a !== 8'd20 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL exact_vend: got credit=%0d busy=%0b expected 20 1", credit_a, busy_a);
        end
        @(posedge clock);
        #1;
        checks++;
        if (credit_a !== 8'd0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL exact_after: got credit=%0d busy=%0b expected 0 0", credit_a, busy_a);
        end
        wait_idle_drained("exact");
    endtask

    task automatic test_change();
        q_prod.push_back(8'd25);
        q_chg.push_back({1'b0, 8'd5});
        drive_a(3'b100, 1'b0);
        wait_idle_drained("change");
        checks++;
        if (credit_a !== 8'd0) begin errors++; $display("FAIL change_final: got %0d expected 0", credit_a); end
    endtask

    task automatic test_refund();
        q_chg.push_back({1'b1, 8'd10});
        q_chg.push_back({1'b1, 8'd5});
        drive_a(3'b010, 1'b0);
        drive_a(3'b000, 1'b1);
        checks++;
        if (refunding_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL refund_enter: got refunding=%0b busy=%0b expected 1 1", refunding_a, busy_a);
        end
        wait_idle_drained("refund");
        checks++;
        if (credit_a !== 8'd0) begin errors++; $display("FAIL refund_final: got %0d expected 0", credit_a); end
    endtask

    task automatic test_reject();
        q_prod.push_back(8'd25);
        q_chg.push_back({1'b0, 8'd5});
        q_rej.push_back(8'd5);
        drive_a(3'b100, 1'b0);
        drive_a(3'b001, 1'b0);
        wait_idle_drained("reject_busy");
        checks++;
        if (credit_a !== 8'd0) begin errors++; $display("FAIL reject_busy_credit: got %0d expected 0", credit_a); end
        q_rej.push_back(8'd5);
        q_chg.push_back({1'b1, 8'd5});
        drive_a(3'b011, 1'b0);
        checks++;
        if (credit_a !== 8'd5 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reject_multi: got credit=%0d busy=%0b expected 5 0", credit_a, busy_a);
        end
        @(posedge clock);
        #1;
        drive_a(3'b000, 1'b1);
        wait_idle_drained("reject_multi");
    endtask

    task automatic test_cancel_coin();
        q_rej.push_back(8'd5);
        q_chg.push_back({1'b1, 8'd5});
        drive_a(3'b001, 1'b0);
        drive_a(3'b010, 1'b1);
        wait_idle_drained("cancel_coin");
        checks++;
        if (credit_a !== 8'd0) begin errors++; $display("FAIL cancel_coin_credit: got %0d expected 0", credit_a); end
        drive_a(3'b001, 1'b1);
        checks++;
        if (credit_a !== 8'd5 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL cancel_zero: got credit=%0d busy=%0b expected 5 0", credit_a, busy_a);
        end
        wait_idle_drained("cancel_zero");
        q_chg.push_back({1'b1, 8'd5});
        drive_a(3'b000, 1'b1);
        wait_idle_drained("cancel_cleanup");
    endtask

    task automatic test_back_to_back();
        q_prod.push_back(8'd20);
        q_prod.push_back(8'd25);
        q_chg.push_back({1'b0, 8'd5});
        drive_a(3'b010, 1'b0);
        drive_a(3'b010, 1'b0);
        @(posedge clock);
        #1;
        drive_a(3'b100, 1'b0);
        wait_idle_drained("back_to_back");
    endtask

    task automatic test_param_reset();
        int pulses;
        coin_b = 3'b100;
        @(posedge clock);
        #1;
        coin_b = 3'b000;
        checks++;
        if (credit_b !== 7'd50 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL param_credit: got credit=%0d busy=%0b expected 50 1", credit_b, busy_b);
        end
        checks++;
        if (product_b !== 1'b1) begin errors++; $display("FAIL param_product: got %0b expected 1", product_b); end
        @(posedge clock);
        #1;
        checks++;
        if (change_b !== 1'b1 || refunding_b !== 1'b0 || credit_b !== 7'd15) begin
            errors++;
            $display("FAIL param_pulse1: got c=%0b r=%0b credit=%0d expected 1 0 15", change_b, refunding_b, credit_b);
        end
        @(posedge clock);
        #1;
        checks++;
        if (change_b !== 1'b1 || credit_b !== 7'd10) begin
            errors++;
            $display("FAIL param_pulse2: got c=%0b credit=%0d expected 1 10", change_b, credit_b);
        end
        reset_b = 1'b1;
        #1;
        checks++;
        if (change_b !== 1'b0 || product_b !== 1'b0 || busy_b !== 1'b0 || credit_b !== 7'd0) begin
            errors++;
            $display("FAIL param_async_reset: got c=%0b p=%0b b=%0b credit=%0d expected 0 0 0 0",
                     change_b, product_b, busy_b, credit_b);
        end
        @(posedge clock);
        #1;
        reset_b = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clock);
            if (change_b || product_b) pulses++;
        end
        checks++;
        if (pulses != 0 || credit_b !== 7'd0) begin
            errors++;
            $display("FAIL param_after_reset: got pulses=%0d credit=%0d expected 0 0", pulses, credit_b);
        end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_change();
        test_refund();
        test_reject();
        test_cancel_coin();
        test_back_to_back();
        test_param_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_ctrl_change.md
Name: vending_ctrl_change

Overview:
Parametrised successor to the team's single-price vending FSM. Accumulates coin credit in a counter instead of fixed credit states, vends when credit reaches PRICE, and returns surplus as a serial stream of CHANGE_UNIT coins. Adds a cancel/refund path and rejects coins while busy. Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
PRICE, 20, product price in rupees; must be a multiple of CHANGE_UNIT and greater than 0.
CHANGE_UNIT, 5, value of one change/refund coin in rupees.
COIN0_VAL, 5, value of coin_in[0] in rupees.
COIN1_VAL, 10, value of coin_in[1] in rupees.
COIN2_VAL, 25, value of coin_in[2] in rupees.
CREDIT_W, 8, credit counter width; must hold PRICE - CHANGE_UNIT + max(COINx_VAL). All COINx_VAL are multiples of CHANGE_UNIT.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; forces the reset state below.
coin_in  in  3  one-cycle coin-detect pulses; bit i carries value COINi_VAL.
cancel  in  1  one-cycle request to refund the current credit.
product  out  1  one-cycle dispense pulse.
change_coin  out  1  one-cycle pulse per CHANGE_UNIT coin returned.
refunding  out  1  high while change_coin pulses are a refund rather than change.
coin_reject  out  1  one-cycle pulse: a coin was sampled but not credited.
busy  out  1  high in any state other than COLLECT.
credit  out  CREDIT_W  current credit in rupees (registered).

Behaviour:
- Reset (asynchronous): state=COLLECT, credit=0, all 1-bit outputs 0.
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.
- Coin priority when more than one coin_in bit is high: bit0 > bit1 > bit2. Only the winning coin is credited. Each other high bit produces coin_reject=1 on the following cycle (one pulse total, not one per coin).
- States: COLLECT, VEND, CHANGE, REFUND.
- COLLECT, cancel=1 with credit>0:
  - Go to REFUND next edge.
  - Any coin sampled in the same cycle is not credited and produces coin_reject.
- COLLECT, cancel=1 with credit=0: cancel is ignored. A coin in that cycle is processed normally.
- COLLECT, coin accepted:
  - credit <= credit + value.
  - If the new credit is at least PRICE, go to VEND next edge. Otherwise stay in COLLECT.
- VEND (exactly 1 cycle):
  - product=1.
  - credit <= credit - PRICE.
  - Go to CHANGE if the remainder is greater than 0, else COLLECT.
- CHANGE:
  - Each cycle: change_coin=1, refunding=0, credit <= credit - CHANGE_UNIT.
  - Return to COLLECT on the edge where credit reaches 0.
- REFUND: same as CHANGE, but refunding=1.
- Latency: product is high in the cycle after the edge that sampled the completing coin. The first change_coin follows in the next cycle.
- Coins sampled while busy=1 are not credited and produce coin_reject the next cycle. cancel is ignored while busy.
- Credit never exceeds PRICE - CHANGE_UNIT + max(COINx_VAL), so there is no overflow path.
- Reset mid-VEND, mid-CHANGE or mid-REFUND: credit is discarded, product and change_coin drop immediately, state returns to COLLECT.

Test Plan:
- Defaults: coin bits 0,0,1 (5,5,10) on three consecutive cycles -> credit 5,10,20; product=1 for exactly one cycle; credit=0; zero change_coin pulses; busy back low after 1 cycle.
- Defaults: single coin_in[2] (25) from idle -> product one cycle, then exactly 1 change_coin with refunding=0, credit 25->5->0.
- Defaults: 10 then cancel -> REFUND, 2 change_coin pulses with refunding=1, credit 10->5->0; product never asserts.
- Coin pulsed during VEND/CHANGE -> coin_reject one cycle later, credit unchanged. coin_in=3'b011 in COLLECT -> only 5 credited, one coin_reject.
- cancel together with coin_in[1] at credit=5 -> refund of 5 only (1 pulse), coin_reject=1. cancel at credit=0 with coin_in[0] -> credit=5, no refund.
- PRICE=35, COIN2_VAL=50, CREDIT_W=7: coin 50 -> product, then 3 change_coin pulses. Assert reset during the 2nd pulse -> credit=0, state COLLECT, no further pulses.
